// File: rtl/uart_paddle_ctrl_pkg.sv
// Shared key constants, command and paddle-state encodings for the UART paddle controller.
package pong_uart_pkg;

  localparam logic [7:0] KEY_P1_UP_LC   = 8'h77;  // 'w'
  localparam logic [7:0] KEY_P1_UP_UC   = 8'h57;  // 'W'
  localparam logic [7:0] KEY_P1_DN_LC   = 8'h73;  // 's'
  localparam logic [7:0] KEY_P1_DN_UC   = 8'h53;  // 'S'
  localparam logic [7:0] KEY_P2_UP_LC   = 8'h6F;  // 'o'
  localparam logic [7:0] KEY_P2_UP_UC   = 8'h4F;  // 'O'
  localparam logic [7:0] KEY_P2_DN_LC   = 8'h6C;  // 'l'
  localparam logic [7:0] KEY_P2_DN_UC   = 8'h4C;  // 'L'
  localparam logic [7:0] KEY_PAUSE      = 8'h20;  // space has no case
  localparam logic [7:0] KEY_RESTART_LC = 8'h72;  // 'r'
  localparam logic [7:0] KEY_RESTART_UC = 8'h52;  // 'R'

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    UP   = 2'b01,
    DOWN = 2'b10
  } paddle_state_e;

  typedef enum logic [2:0] {
    CMD_NONE,
    CMD_P1_UP,
    CMD_P1_DN,
    CMD_P2_UP,
    CMD_P2_DN,
    CMD_PAUSE,
    CMD_RESTART
  } cmd_e;

  function automatic cmd_e decode_key(input logic [7:0] key);
    case (key)
      KEY_P1_UP_LC,   KEY_P1_UP_UC:   return CMD_P1_UP;
      KEY_P1_DN_LC,   KEY_P1_DN_UC:   return CMD_P1_DN;
      KEY_P2_UP_LC,   KEY_P2_UP_UC:   return CMD_P2_UP;
      KEY_P2_DN_LC,   KEY_P2_DN_UC:   return CMD_P2_DN;
      KEY_PAUSE:                      return CMD_PAUSE;
      KEY_RESTART_LC, KEY_RESTART_UC: return CMD_RESTART;
      default:                        return CMD_NONE;
    endcase
  endfunction

endpackage

// File: rtl/uart_paddle_ctrl_if.sv
// Byte input from the UART receiver plus the paddle/game command outputs.
// bad_byte_cnt exists only when UART_BAD_BYTE_CNT_EN is defined.
interface uart_paddle_ctrl_if;
  logic       data_valid;
  logic [7:0] data_byte;
  logic       p1_up;
  logic       p1_down;
  logic       p2_up;
  logic       p2_down;
  logic       paused;
  logic       game_rst;
`ifdef UART_BAD_BYTE_CNT_EN
  logic [7:0] bad_byte_cnt;

  modport master (output data_valid, data_byte,
                  input  p1_up, p1_down, p2_up, p2_down, paused, game_rst, bad_byte_cnt);
  modport slave  (input  data_valid, data_byte,
                  output p1_up, p1_down, p2_up, p2_down, paused, game_rst, bad_byte_cnt);
`else
  modport master (output data_valid, data_byte,
                  input  p1_up, p1_down, p2_up, p2_down, paused, game_rst);
  modport slave  (input  data_valid, data_byte,
                  output p1_up, p1_down, p2_up, p2_down, paused, game_rst);
`endif
endinterface

// File: rtl/uart_paddle_ctrl_hold_fsm.sv
// Per-player IDLE/UP/DOWN FSM; a motion key holds its direction for HOLD_CYCLES clocks.
module paddle_hold_fsm
  import pong_uart_pkg::*;
#(
  parameter int HOLD_CYCLES = 2_500_000
) (
  input  logic clk_in,
  input  logic rst_in,
  input  logic key_up,
  input  logic key_dn,
  input  logic force_idle,
  output logic up,
  output logic down
);

  localparam int              CW        = $clog2(HOLD_CYCLES);
  localparam logic [CW-1:0]   HOLD_LOAD = CW'(HOLD_CYCLES - 1);

  paddle_state_e state, state_nxt;
  logic [CW-1:0] hold_cnt, hold_nxt;

  // NOTE: sequential state uses <= so every register samples pre-edge values.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state    <= IDLE;
      hold_cnt <= '0;
    end else begin
      state    <= state_nxt;
      hold_cnt <= hold_nxt;
    end
  end

  // NOTE: defaults first so no path leaves state_nxt/hold_nxt unassigned (no latch).
  always_comb begin
    state_nxt = state;
    hold_nxt  = hold_cnt;
    if (force_idle) begin
      state_nxt = IDLE;
      hold_nxt  = '0;
    end else if (key_up) begin
      state_nxt = UP;
      hold_nxt  = HOLD_LOAD;
    end else if (key_dn) begin
      state_nxt = DOWN;
      hold_nxt  = HOLD_LOAD;
    end else if (state != IDLE) begin
      if (hold_cnt == '0) state_nxt = IDLE;
      else                hold_nxt  = hold_cnt - CW'(1);
    end
  end

  always_comb begin
    up   = (state == UP);
    down = (state == DOWN);
  end

endmodule

// File: rtl/uart_paddle_ctrl.sv
// UART key decoder for pong: data_valid edge detect, pause/restart and two paddle hold FSMs.
// Define UART_BAD_BYTE_CNT_EN to add the saturating unrecognised-byte counter.
module uart_paddle_ctrl
  import pong_uart_pkg::*;
#(
  parameter int HOLD_CYCLES = 2_500_000
) (
  input  logic             clk_in,
  input  logic             rst_in,
  uart_paddle_ctrl_if.slave bus
);

  logic dv_q;
  logic accept;
  cmd_e cmd;
  logic paused_q;
  logic game_rst_q;
  logic force_idle;
  logic p1_key_up, p1_key_dn, p2_key_up, p2_key_dn;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) dv_q <= 1'b0;
    else        dv_q <= bus.data_valid;
  end

  // A long data_valid pulse is a single byte: only its rising edge is accepted.
  assign accept = bus.data_valid & ~dv_q;
  assign cmd    = accept ? decode_key(bus.data_byte) : CMD_NONE;

  always_comb begin
    p1_key_up  = (cmd == CMD_P1_UP) & ~paused_q;
    p1_key_dn  = (cmd == CMD_P1_DN) & ~paused_q;
    p2_key_up  = (cmd == CMD_P2_UP) & ~paused_q;
    p2_key_dn  = (cmd == CMD_P2_DN) & ~paused_q;
    force_idle = (cmd == CMD_RESTART) | ((cmd == CMD_PAUSE) & ~paused_q);
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      paused_q   <= 1'b0;
      game_rst_q <= 1'b0;
    end else begin
      game_rst_q <= (cmd == CMD_RESTART);
      if (cmd == CMD_RESTART)    paused_q <= 1'b0;
      else if (cmd == CMD_PAUSE) paused_q <= ~paused_q;
    end
  end

  assign bus.paused   = paused_q;
  assign bus.game_rst = game_rst_q;

`ifdef UART_BAD_BYTE_CNT_EN
  logic [7:0] bad_cnt_q;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in)
      bad_cnt_q <= '0;
    else if (accept && cmd == CMD_NONE && bad_cnt_q != 8'hFF)
      bad_cnt_q <= bad_cnt_q + 8'd1;
  end

  assign bus.bad_byte_cnt = bad_cnt_q;
`endif

  paddle_hold_fsm #(.HOLD_CYCLES(HOLD_CYCLES)) u_p1 (
    .clk_in     (clk_in),
    .rst_in     (rst_in),
    .key_up     (p1_key_up),
    .key_dn     (p1_key_dn),
    .force_idle (force_idle),
    .up         (bus.p1_up),
    .down       (bus.p1_down)
  );

  paddle_hold_fsm #(.HOLD_CYCLES(HOLD_CYCLES)) u_p2 (
    .clk_in     (clk_in),
    .rst_in     (rst_in),
    .key_up     (p2_key_up),
    .key_dn     (p2_key_dn),
    .force_idle (force_idle),
    .up         (bus.p2_up),
    .down       (bus.p2_down)
  );

endmodule
